// File: rtl/rv_soc_apb_mux_tmo.sv
// APB4 decoder/mux: one master port split into SLAVES regions, with an unmapped-region error responder and a wait-state watchdog.
// Latency: zero added cycles (combinational response path). Backpressure: the slave PREADY is passed through, and a hung slave is aborted after TIMEOUT waits.
// Optional sticky error status registers are built when RV_SOC_APB_MUX_STATUS_EN is defined.
module rv_soc_apb_mux_tmo #(
    parameter int PADDR_SIZE = 12,
    parameter int PDATA_SIZE = 32,
    parameter int SLAVES     = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic [PADDR_SIZE-1:0]        PADDR,
    output logic [PDATA_SIZE-1:0]        PRDATA,
    output logic                         PREADY,
    output logic                         PSLVERR,
    output logic [SLAVES-1:0]            slv_PSEL,
    input  logic [SLAVES*PDATA_SIZE-1:0] slv_PRDATA,
    input  logic [SLAVES-1:0]            slv_PREADY,
    input  logic [SLAVES-1:0]            slv_PSLVERR
`ifdef RV_SOC_APB_MUX_STATUS_EN
    ,
    output logic                         err_valid,
    output logic                         err_tmo,
    output logic [PADDR_SIZE-1:0]        err_addr,
    input  logic                         err_clr
`endif
);
    localparam int SEL_BITS = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam int CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WDOG_EN  = (TIMEOUT != 0);
    localparam logic [SEL_BITS:0] NUM_SLV  = (SEL_BITS + 1)'(SLAVES);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [SEL_BITS-1:0]   idx;
    logic                  mapped;
    logic                  fire;
    logic                  unused_addr;

    assign idx         = PADDR[PADDR_SIZE-1 -: SEL_BITS];
    assign mapped      = ({1'b0, idx} < NUM_SLV);
    assign unused_addr = ^PADDR;

    // Select gated by PRESETn so every slave select drops as soon as reset is asserted
    always_comb begin
        slv_PSEL = '0;
        PRDATA   = '0;
        PREADY   = 1'b1;
        PSLVERR  = 1'b0;
        if (state == ABORT) begin
            PSLVERR = 1'b1;
        end else if (PSEL) begin
            if (mapped) begin
                PREADY = 1'b0;
                for (int i = 0; i < SLAVES; i++) begin
                    if (idx == SEL_BITS'(i)) begin
                        slv_PSEL[i] = PRESETn;
                        PRDATA      = slv_PRDATA[i*PDATA_SIZE +: PDATA_SIZE];
                        PREADY      = slv_PREADY[i];
                        PSLVERR     = slv_PSLVERR[i];
                    end
                end
            end else begin
                PSLVERR = 1'b1;
            end
        end
    end

    // Slave readiness is folded into PREADY, so a late ready always beats the watchdog
    assign fire = WDOG_EN && (state == ACCESS) && PSEL && PENABLE && !PREADY && (cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (!PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end else if (PREADY) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (fire) begin
                    state_nxt = ABORT;
                    cnt_nxt   = '0;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ABORT: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef RV_SOC_APB_MUX_STATUS_EN
    logic err_evt;
    logic err_evt_tmo;

    assign err_evt_tmo = (state == ABORT);
    assign err_evt     = err_evt_tmo || (PSEL && PENABLE && PREADY && PSLVERR);

    // First error is sticky; a clear in the same cycle as a new error keeps the new one
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_valid <= 1'b0;
            err_tmo   <= 1'b0;
            err_addr  <= '0;
        end else if (err_evt && (!err_valid || err_clr)) begin
            err_valid <= 1'b1;
            err_tmo   <= err_evt_tmo;
            err_addr  <= PADDR;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_tmo   <= 1'b0;
            err_addr  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_rv_soc_apb_mux_tmo.sv
// Bench for rv_soc_apb_mux_tmo: DUT A (4 slaves, TIMEOUT=16) and DUT B (3 slaves, watchdog off) share one master bus.
// Expected responses are queued per DUT, and a negedge monitor pops and compares them on each completed transfer.
module tb_rv_soc_apb_mux_tmo;
    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
        logic [3:0]  sel;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         psel, penable;
    logic [11:0]  paddr;
    int           tgt;

    logic [31:0]  a_prdata;
    logic         a_pready, a_pslverr;
    logic [3:0]   a_sel;
    logic [127:0] a_sdata;
    logic [3:0]   a_rdy, a_err;

    logic [31:0]  b_prdata;
    logic         b_pready, b_pslverr;
    logic [2:0]   b_sel;
    logic [95:0]  b_sdata;
    logic [2:0]   b_rdy, b_err;

`ifdef RV_SOC_APB_MUX_STATUS_EN
    logic         a_err_valid, a_err_tmo, err_clr;
    logic [11:0]  a_err_addr;
    logic         b_unused_vld, b_unused_tmo;
    logic [11:0]  b_unused_addr;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rv_soc_apb_mux_tmo #(.PADDR_SIZE(12), .PDATA_SIZE(32), .SLAVES(4), .TIMEOUT(16)) dut_a (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
        .PRDATA(a_prdata), .PREADY(a_pready), .PSLVERR(a_pslverr),
        .slv_PSEL(a_sel), .slv_PRDATA(a_sdata), .slv_PREADY(a_rdy), .slv_PSLVERR(a_err)
`ifdef RV_SOC_APB_MUX_STATUS_EN
        , .err_valid(a_err_valid), .err_tmo(a_err_tmo), .err_addr(a_err_addr), .err_clr(err_clr)
`endif
    );

    rv_soc_apb_mux_tmo #(.PADDR_SIZE(12), .PDATA_SIZE(32), .SLAVES(3), .TIMEOUT(0)) dut_b (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
        .PRDATA(b_prdata), .PREADY(b_pready), .PSLVERR(b_pslverr),
        .slv_PSEL(b_sel), .slv_PRDATA(b_sdata), .slv_PREADY(b_rdy), .slv_PSLVERR(b_err)
`ifdef RV_SOC_APB_MUX_STATUS_EN
        , .err_valid(b_unused_vld), .err_tmo(b_unused_tmo), .err_addr(b_unused_addr), .err_clr(err_clr)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the completing posedge with the bus idle.
    task automatic xfer(input int d, input logic [11:0] addr, input int waits, input logic serr,
                        input logic [31:0] ex_data, input logic ex_err, input int ex_waits,
                        input logic [3:0] ex_sel);
        exp_t       e;
        int         k;
        int         idx;
        bit         done;
        logic [3:0] onehot;
        e.data  = ex_data;
        e.err   = ex_err;
        e.waits = ex_waits;
        e.sel   = ex_sel;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
        idx    = int'(addr[11:10]);
        onehot = 4'b0001 << idx;
        tgt     = d;
        paddr   = addr;
        psel    = 1'b1;
        penable = 1'b0;
        if (d == 0) begin
            a_rdy = '0;
            a_err = serr ? onehot : 4'b0000;
        end else begin
            b_rdy = '0;
            b_err = serr ? onehot[2:0] : 3'b000;
        end
        @(posedge clk); #1;
        penable = 1'b1;
        k    = 0;
        done = 1'b0;
        while (!done) begin
            if (d == 0) a_rdy = (k >= waits) ? onehot : 4'b0000;
            else        b_rdy = (k >= waits) ? onehot[2:0] : 3'b000;
            @(negedge clk);
            done = (d == 0) ? a_pready : b_pready;
            @(posedge clk); #1;
            k++;
            if (!done && k > 1100) begin
                checks++;
                errors++;
                $display("FAIL xfer_timeout: addr 0x%0h got no PREADY within %0d cycles", addr, k);
                done = 1'b1;
            end
        end
        psel    = 1'b0;
        penable = 1'b0;
        a_rdy   = '1;
        a_err   = '0;
        b_rdy   = '1;
        b_err   = '0;
    endtask

    initial begin : monitor
        int   wa;
        int   wb;
        exp_t e;
        wa = 0;
        wb = 0;
        forever begin
            @(negedge clk);
            if (rst_n && psel && penable && tgt == 0) begin
                if (a_pready) begin
                    if (qa.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL a_unexpected: completion at addr 0x%0h with nothing expected", paddr);
                    end else begin
                        e = qa.pop_front();
                        check("a_prdata", a_prdata, e.data);
                        check("a_pslverr", a_pslverr, e.err);
                        check("a_waits", wa, e.waits);
                        check("a_slv_psel", a_sel, e.sel);
                    end
                    wa = 0;
                end else wa++;
            end else wa = 0;
            if (rst_n && psel && penable && tgt == 1) begin
                if (b_pready) begin
                    if (qb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_unexpected: completion at addr 0x%0h with nothing expected", paddr);
                    end else begin
                        e = qb.pop_front();
                        check("b_prdata", b_prdata, e.data);
                        check("b_pslverr", b_pslverr, e.err);
                        check("b_waits", wb, e.waits);
                        check("b_slv_psel", {1'b0, b_sel}, e.sel);
                    end
                    wb = 0;
                end else wb++;
            end else wb = 0;
        end
    end

    initial begin
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        paddr   = '0;
        tgt     = 0;
        a_sdata = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        b_sdata = {32'hB0B0_0002, 32'hB0B0_0001, 32'hB0B0_0000};
        a_rdy   = '1;
        a_err   = '0;
        b_rdy   = '1;
        b_err   = '0;
`ifdef RV_SOC_APB_MUX_STATUS_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_slv_psel", a_sel, 4'b0000);
        check("rst_pready", a_pready, 1'b1);
        check("rst_pslverr", a_pslverr, 1'b0);
        check("rst_prdata", a_prdata, 32'h0);
`ifdef RV_SOC_APB_MUX_STATUS_EN
        check("rst_err_valid", a_err_valid, 1'b0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 12'h812, 3, 1'b0, 32'hA5A5_0002, 1'b0, 3, 4'b0100);
        xfer(0, 12'h400, 0, 1'b0, 32'hA5A5_0001, 1'b0, 0, 4'b0010);
        xfer(0, 12'h4F0, 15, 1'b0, 32'hA5A5_0001, 1'b0, 15, 4'b0010);
`ifdef RV_SOC_APB_MUX_STATUS_EN
        check("late_ready_err_valid", a_err_valid, 1'b0);
`endif
        xfer(0, 12'h000, 0, 1'b1, 32'hA5A5_0000, 1'b1, 0, 4'b0001);
        xfer(0, 12'hC04, 2, 1'b1, 32'hA5A5_0003, 1'b1, 2, 4'b1000);
`ifdef RV_SOC_APB_MUX_STATUS_EN
        check("sticky_err_valid", a_err_valid, 1'b1);
        check("sticky_err_tmo", a_err_tmo, 1'b0);
        check("sticky_err_addr", a_err_addr, 12'h000);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("clr_err_valid", a_err_valid, 1'b0);
        check("clr_err_addr", a_err_addr, 12'h000);
`endif
        xfer(0, 12'h404, 1000, 1'b0, 32'h0, 1'b1, 16, 4'b0000);
`ifdef RV_SOC_APB_MUX_STATUS_EN
        check("abort_err_valid", a_err_valid, 1'b1);
        check("abort_err_tmo", a_err_tmo, 1'b1);
        check("abort_err_addr", a_err_addr, 12'h404);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
`endif

        // Reset in the middle of a slow transfer
        tgt     = 0;
        paddr   = 12'h808;
        psel    = 1'b1;
        penable = 1'b0;
        a_rdy   = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_slv_psel", a_sel, 4'b0000);
        psel    = 1'b0;
        penable = 1'b0;
        a_rdy   = '1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(0, 12'h812, 1, 1'b0, 32'hA5A5_0002, 1'b0, 1, 4'b0100);

        xfer(1, 12'hC00, 0, 1'b0, 32'h0, 1'b1, 0, 4'b0000);
        xfer(1, 12'h8A0, 2, 1'b1, 32'hB0B0_0002, 1'b1, 2, 4'b0100);
        xfer(1, 12'h400, 1000, 1'b0, 32'hB0B0_0001, 1'b0, 1000, 4'b0010);

        @(posedge clk); #1;
        check("idle_a_pready", a_pready, 1'b1);
        check("idle_b_pready", b_pready, 1'b1);
        check("idle_b_pslverr", b_pslverr, 1'b0);
        check("idle_b_prdata", b_prdata, 32'h0);
        check("idle_b_slv_psel", b_sel, 3'b000);
        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
